// File: rtl/stage_wb_multi.sv
// ----------------------------------------------------------------------------
// stage_wb_multi
//   Writeback stage for a bundle of LANES instructions. It holds one bundle,
//   commits its register writes exactly once (on retirement), exposes the held
//   results for hazard/forwarding logic and counts retired lanes.
//
// Parameters
//   DATA_W  register/PC data width
//   ADDR_W  register address width
//   LANES   instructions per bundle (1..4); lane i lives at [i*W +: W]
//   CNT_W   retired-lane counter width (wraps)
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   validin / allowin           upstream handshake
//   validout / allowout         downstream (retirement) handshake
//   flush                       drop the held bundle without writing
//   input_lane_valid/pc/rf_we/rf_waddr/rf_wdata   per-lane bundle contents
//   rf_we/rf_waddr/rf_wdata     register file write ports, one per lane
//   fwd_valid/fwd_waddr/fwd_wdata   held results for forwarding
//   retired_cnt                 lanes retired since reset
//
// Optional build macro WB_TRACE_EN adds debug_wb_pc, debug_wb_rf_we (4 bits per
// lane), debug_wb_rf_wnum and debug_wb_rf_wdata trace outputs.
//
// Handshake: a bundle transfers into this stage on a rising edge where
// validin & allowin; it retires on a rising edge where validout & allowout
// (fire). allowin = !valid | allowout, so a bundle may enter in the same
// cycle the previous one retires. The stage is always ready to go.
// ----------------------------------------------------------------------------
module stage_wb_multi #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      validin,
  output logic                      allowin,
  output logic                      validout,
  input  logic                      allowout,
  input  logic                      flush,
  input  logic [LANES-1:0]          input_lane_valid,
  input  logic [LANES*DATA_W-1:0]   input_pc,
  input  logic [LANES-1:0]          input_rf_we,
  input  logic [LANES*ADDR_W-1:0]   input_rf_waddr,
  input  logic [LANES*DATA_W-1:0]   input_rf_wdata,
  output logic [LANES-1:0]          rf_we,
  output logic [LANES*ADDR_W-1:0]   rf_waddr,
  output logic [LANES*DATA_W-1:0]   rf_wdata,
  output logic [LANES-1:0]          fwd_valid,
  output logic [LANES*ADDR_W-1:0]   fwd_waddr,
  output logic [LANES*DATA_W-1:0]   fwd_wdata,
  output logic [CNT_W-1:0]          retired_cnt
`ifdef WB_TRACE_EN
  ,
  output logic [LANES*DATA_W-1:0]   debug_wb_pc,
  output logic [LANES*4-1:0]        debug_wb_rf_we,
  output logic [LANES*ADDR_W-1:0]   debug_wb_rf_wnum,
  output logic [LANES*DATA_W-1:0]   debug_wb_rf_wdata
`endif
);

  logic                    valid;
  logic [LANES-1:0]        lane_valid_q;
  logic [LANES*DATA_W-1:0] pc_q;
  logic [LANES-1:0]        we_q;
  logic [LANES*ADDR_W-1:0] waddr_q;
  logic [LANES*DATA_W-1:0] wdata_q;

  logic                    fire;
  logic                    load;
  logic [LANES-1:0]        ew;        // lane really writes a non-zero register
  logic [LANES-1:0]        sup;       // lane overwritten by a higher lane in bundle
  logic [CNT_W-1:0]        lane_pop;

  assign allowin  = !valid || allowout;
  assign validout = valid;
  assign fire     = valid && allowout;
  assign load     = validin && allowin;

  always_comb begin
    ew  = '0;
    sup = '0;
    for (int i = 0; i < LANES; i++) begin
      ew[i] = lane_valid_q[i] && we_q[i] && (waddr_q[i*ADDR_W +: ADDR_W] != '0);
    end
    // Intra-bundle WAW: only the highest lane writing a given register commits.
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (ew[i] && ew[j] &&
            (waddr_q[i*ADDR_W +: ADDR_W] == waddr_q[j*ADDR_W +: ADDR_W])) begin
          sup[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    lane_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_pop = lane_pop + CNT_W'(lane_valid_q[i]);
    end
  end

  // Writes are gated by fire, which is true for exactly one cycle per bundle,
  // so a stalled bundle never writes twice.
  assign rf_we     = (fire && !flush) ? (ew & ~sup) : '0;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign fwd_valid = valid ? (ew & ~sup) : '0;
  assign fwd_waddr = waddr_q;
  assign fwd_wdata = wdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid        <= 1'b0;
      lane_valid_q <= '0;
      pc_q         <= '0;
      we_q         <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid        <= 1'b1;
      lane_valid_q <= input_lane_valid;
      pc_q         <= input_pc;
      we_q         <= input_rf_we;
      waddr_q      <= input_rf_waddr;
      wdata_q      <= input_rf_wdata;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retired_cnt <= '0;
    end else if (fire && !flush) begin
      retired_cnt <= retired_cnt + lane_pop;
    end
  end

`ifdef WB_TRACE_EN
  always_comb begin
    debug_wb_rf_we = '0;
    for (int i = 0; i < LANES; i++) begin
      debug_wb_rf_we[i*4 +: 4] = {4{rf_we[i]}};
    end
  end
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wnum  = waddr_q;
  assign debug_wb_rf_wdata = wdata_q;
`endif

endmodule

// File: tb/tb_stage_wb_multi.sv
// ----------------------------------------------------------------------------
// tb_stage_wb_multi
//   Directed bench for stage_wb_multi with two lanes and a 4-bit retired
//   counter (so wrap-around is reachable). Single-lane scenarios keep lane 1
//   invalid. Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_stage_wb_multi;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LANES  = 2;
  localparam int CNT_W  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic                      validin = 1'b0;
  logic                      allowin;
  logic                      validout;
  logic                      allowout = 1'b1;
  logic                      flush = 1'b0;
  logic [LANES-1:0]          input_lane_valid = '0;
  logic [LANES*DATA_W-1:0]   input_pc = '0;
  logic [LANES-1:0]          input_rf_we = '0;
  logic [LANES*ADDR_W-1:0]   input_rf_waddr = '0;
  logic [LANES*DATA_W-1:0]   input_rf_wdata = '0;
  logic [LANES-1:0]          rf_we;
  logic [LANES*ADDR_W-1:0]   rf_waddr;
  logic [LANES*DATA_W-1:0]   rf_wdata;
  logic [LANES-1:0]          fwd_valid;
  logic [LANES*ADDR_W-1:0]   fwd_waddr;
  logic [LANES*DATA_W-1:0]   fwd_wdata;
  logic [CNT_W-1:0]          retired_cnt;
`ifdef WB_TRACE_EN
  logic [LANES*DATA_W-1:0]   debug_wb_pc;
  logic [LANES*4-1:0]        debug_wb_rf_we;
  logic [LANES*ADDR_W-1:0]   debug_wb_rf_wnum;
  logic [LANES*DATA_W-1:0]   debug_wb_rf_wdata;
`endif

  stage_wb_multi #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .CNT_W(CNT_W)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .validin          (validin),
    .allowin          (allowin),
    .validout         (validout),
    .allowout         (allowout),
    .flush            (flush),
    .input_lane_valid (input_lane_valid),
    .input_pc         (input_pc),
    .input_rf_we      (input_rf_we),
    .input_rf_waddr   (input_rf_waddr),
    .input_rf_wdata   (input_rf_wdata),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .fwd_valid        (fwd_valid),
    .fwd_waddr        (fwd_waddr),
    .fwd_wdata        (fwd_wdata),
    .retired_cnt      (retired_cnt)
`ifdef WB_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present a bundle (lane 1 pc = lane 0 pc + 4)
  task automatic drive_bundle(input logic [1:0] lv, input logic [1:0] we,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] pc0);
    validin          = 1'b1;
    input_lane_valid = lv;
    input_rf_we      = we;
    input_rf_waddr   = {a1, a0};
    input_rf_wdata   = {d1, d0};
    input_pc         = {pc0 + 32'd4, pc0};
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // ---- reset state
    @(negedge clk);
    check("rst_allowin", 64'(allowin), 64'd1);
    check("rst_validout", 64'(validout), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst_cnt", 64'(retired_cnt), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // ---- 1: single-lane write
    allowout = 1'b1;
    drive_bundle(2'b01, 2'b01, 5'd3, 5'd0, 32'hdeadbeef, 32'h0, 32'h1c000000);
    cycle();
    validin = 1'b0;
    check("t1_rf_we", 64'(rf_we), 64'd1);
    check("t1_waddr", 64'(rf_waddr[4:0]), 64'd3);
    check("t1_wdata", 64'(rf_wdata[31:0]), 64'hdeadbeef);
    check("t1_fwd_valid", 64'(fwd_valid), 64'd1);
`ifdef WB_TRACE_EN
    check("t1_dbg_we", 64'(debug_wb_rf_we), 64'h0f);
    check("t1_dbg_pc", 64'(debug_wb_pc[31:0]), 64'h1c000000);
`endif
    cycle();
    check("t1_cnt", 64'(retired_cnt), 64'd1);
    check("t1_idle_rf_we", 64'(rf_we), 64'd0);
    check("t1_idle_validout", 64'(validout), 64'd0);

    // ---- 2: write to r0 is not a write, but still retires
    drive_bundle(2'b01, 2'b01, 5'd0, 5'd0, 32'h12345678, 32'h0, 32'h1c000004);
    cycle();
    validin = 1'b0;
    check("t2_rf_we", 64'(rf_we), 64'd0);
    check("t2_fwd_valid", 64'(fwd_valid), 64'd0);
    check("t2_validout", 64'(validout), 64'd1);
    cycle();
    check("t2_cnt", 64'(retired_cnt), 64'd2);

    // ---- 3: downstream stall for 3 cycles
    allowout = 1'b0;
    drive_bundle(2'b01, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 32'h1c000008);
    cycle();
    validin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t3_stall_allowin", 64'(allowin), 64'd0);
      check("t3_stall_rf_we", 64'(rf_we), 64'd0);
      check("t3_stall_fwd", 64'(fwd_valid), 64'd1);
      check("t3_stall_cnt", 64'(retired_cnt), 64'd2);
      cycle();
    end
    allowout = 1'b1;
    #1;
    check("t3_release_rf_we", 64'(rf_we), 64'd1);
    check("t3_release_allowin", 64'(allowin), 64'd1);
    cycle();
    check("t3_after_rf_we", 64'(rf_we), 64'd0);
    check("t3_cnt", 64'(retired_cnt), 64'd3);

    // ---- 4: intra-bundle WAW, higher lane wins
    drive_bundle(2'b11, 2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 32'h1c000010);
    cycle();
    validin = 1'b0;
    check("t4_rf_we", 64'(rf_we), 64'b10);
    check("t4_fwd_valid", 64'(fwd_valid), 64'b10);
    check("t4_wdata1", 64'(rf_wdata[63:32]), 64'h22);
    cycle();
    check("t4_cnt", 64'(retired_cnt), 64'd5);

    // two lanes, distinct destinations
    drive_bundle(2'b11, 2'b11, 5'd6, 5'd9, 32'h66, 32'h99, 32'h1c000020);
    cycle();
    validin = 1'b0;
    check("t4b_rf_we", 64'(rf_we), 64'b11);
    check("t4b_waddr", 64'(rf_waddr), 64'({5'd9, 5'd6}));
    cycle();
    check("t4b_cnt", 64'(retired_cnt), 64'd7);

    // ---- 5: flush wins over simultaneous load
    flush = 1'b1;
    drive_bundle(2'b01, 2'b01, 5'd4, 5'd0, 32'h44, 32'h0, 32'h1c000030);
    cycle();
    flush = 1'b0;
    validin = 1'b0;
    check("t5_validout", 64'(validout), 64'd0);
    check("t5_rf_we", 64'(rf_we), 64'd0);
    check("t5_cnt", 64'(retired_cnt), 64'd7);

    // flush of a held bundle while downstream accepts
    drive_bundle(2'b01, 2'b01, 5'd8, 5'd0, 32'h88, 32'h0, 32'h1c000040);
    cycle();
    validin = 1'b0;
    flush = 1'b1;
    #1;
    check("t5b_rf_we", 64'(rf_we), 64'd0);
    check("t5b_fwd_valid", 64'(fwd_valid), 64'd1);
    cycle();
    flush = 1'b0;
    check("t5b_validout", 64'(validout), 64'd0);
    check("t5b_cnt", 64'(retired_cnt), 64'd7);

    // ---- back-to-back throughput and counter wrap (7 + 5*2 = 17 -> 1)
    for (int k = 0; k < 5; k++) begin
      drive_bundle(2'b11, 2'b11, 5'(10 + k), 5'(20 + k), 32'(k), 32'(k + 100), 32'h1c000100);
      cycle();
      check("b2b_rf_we", 64'(rf_we), 64'b11);
      check("b2b_waddr", 64'(rf_waddr), 64'({5'(20 + k), 5'(10 + k)}));
    end
    validin = 1'b0;
    cycle();
    check("wrap_cnt", 64'(retired_cnt), 64'd1);
    check("wrap_validout", 64'(validout), 64'd0);

    // ---- 6: async reset with a bundle held
    allowout = 1'b0;
    drive_bundle(2'b11, 2'b11, 5'd12, 5'd13, 32'hc, 32'hd, 32'h1c000200);
    cycle();
    validin = 1'b0;
    check("t6_held_fwd", 64'(fwd_valid), 64'b11);
    allowout = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rf_we", 64'(rf_we), 64'd0);
    check("t6_fwd_valid", 64'(fwd_valid), 64'd0);
    check("t6_cnt", 64'(retired_cnt), 64'd0);
    check("t6_validout", 64'(validout), 64'd0);
`ifdef WB_TRACE_EN
    check("t6_dbg_we", 64'(debug_wb_rf_we), 64'd0);
    check("t6_dbg_pc", 64'(debug_wb_pc), 64'd0);
`endif
    cycle();
    resetn = 1'b1;
    cycle();
    check("t6_post_cnt", 64'(retired_cnt), 64'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
